// File: rtl/alu_md_iter.sv
// alu_md_iter: execute-stage ALU with valid/ready handshakes, a result tag and flush.
// Base integer ops (0000-1001) complete in one cycle. MUL/MULH/DIV/DIVU/REM/REMU
// (1010-1111) are iterative and take XLEN+1 cycles. They are built only when the
// ALU_MULDIV_EN macro is defined. Without it, those opcodes complete in one cycle
// with Result=0, Zero=1 and Illegal=1.
module alu_md_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUcontrol_In,
    input  logic [XLEN-1:0]  A,
    input  logic [XLEN-1:0]  B,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  Result,
    output logic             Zero,
    output logic             Illegal,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100, OP_SLL  = 4'b0101, OP_SRL  = 4'b0110, OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_MUL  = 4'b1010, OP_MULH = 4'b1011,
        OP_DIV  = 4'b1100, OP_DIVU = 4'b1101, OP_REM  = 4'b1110, OP_REMU = 4'b1111
    } op_t;

    logic             idle;
    logic             fire;
    logic [SW-1:0]    shamt;
    logic [XLEN-1:0]  base_res;
    logic             base_ill;
    logic             ld_en;
    logic [XLEN-1:0]  ld_res;
    logic             ld_ill;
    logic [TAG_W-1:0] ld_tag;

    assign in_ready = !rst && !flush && idle && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;
    assign shamt    = B[SW-1:0];

    // Single-cycle base ops; mul/div opcodes fall out as illegal here.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        base_res = '0;
        base_ill = 1'b0;
        case (op_t'(ALUcontrol_In))
            OP_ADD:  base_res = A + B;
            OP_SUB:  base_res = A - B;
            OP_AND:  base_res = A & B;
            OP_OR:   base_res = A | B;
            OP_XOR:  base_res = A ^ B;
            OP_SLL:  base_res = A << shamt;
            OP_SRL:  base_res = A >> shamt;
            OP_SRA:  base_res = $signed(A) >>> shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (A < B)};
            default: base_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int            CW   = SW + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [XLEN-1:0]    hi;      // product high half / partial remainder
    logic [XLEN-1:0]    lo;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]    opnd;    // multiplicand or divisor magnitude
    logic [XLEN-1:0]    a_q;
    logic [3:0]         op_q;
    logic               neg_q;   // product/quotient sign
    logic               rneg_q;  // remainder sign (follows A)
    logic               dz_q;    // divide by zero
    logic [TAG_W-1:0]   tag_q;

    logic               is_md, sgn_op, a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag, quot, rem, md_res;
    logic [XLEN:0]      mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0]  prod, prod_s;

    assign idle     = (state == S_IDLE);
    assign is_md    = ALUcontrol_In[3] && (ALUcontrol_In[2] || ALUcontrol_In[1]);
    assign sgn_op   = !(ALUcontrol_In[2] && ALUcontrol_In[0]);
    assign a_neg    = sgn_op && A[XLEN-1];
    assign b_neg    = sgn_op && B[XLEN-1];
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -B : B;
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign prod     = {hi, lo};
    assign prod_s   = neg_q ? -prod : prod;
    assign quot     = neg_q ? -lo : lo;
    assign rem      = rneg_q ? -hi : hi;

    // Select the finished mul/div result from the latched opcode.
    always_comb begin
        md_res = '0;
        case (op_q)
            4'b1010:          md_res = prod_s[XLEN-1:0];
            4'b1011:          md_res = prod_s[2*XLEN-1:XLEN];
            4'b1100, 4'b1101: md_res = dz_q ? '1 : quot;
            default:          md_res = dz_q ? a_q : rem;
        endcase
    end

    // Output-register load source: base op at accept, or mul/div at the final count.
    always_comb begin
        ld_en  = 1'b0;
        ld_res = base_res;
        ld_ill = base_ill;
        ld_tag = in_tag;
        if (idle) begin
            ld_en = fire && !is_md;
        end else if (cnt == LAST) begin
            ld_en  = 1'b1;
            ld_res = md_res;
            ld_ill = 1'b0;
            ld_tag = tag_q;
        end
    end
`else
    assign idle = 1'b1;

    // Every opcode completes in one cycle when the mul/div unit is not built.
    always_comb begin
        ld_en  = fire;
        ld_res = base_res;
        ld_ill = base_ill;
        ld_tag = in_tag;
    end
`endif

    // FSM, iterative datapath and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: mul/div datapath registers are left unreset; they are always loaded at accept before use.
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            Illegal   <= 1'b0;
            out_tag   <= '0;
`ifdef ALU_MULDIV_EN
            state     <= S_IDLE;
            cnt       <= '0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
`ifdef ALU_MULDIV_EN
            state     <= S_IDLE;
            cnt       <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (ld_en) begin
                out_valid <= 1'b1;
                Result    <= ld_res;
                Zero      <= (ld_res == '0);
                Illegal   <= ld_ill;
                out_tag   <= ld_tag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ALU_MULDIV_EN
            case (state)
                S_IDLE: begin
                    if (fire && is_md) begin
                        state  <= ALUcontrol_In[2] ? S_DIV : S_MUL;
                        cnt    <= '0;
                        op_q   <= ALUcontrol_In;
                        tag_q  <= in_tag;
                        a_q    <= A;
                        dz_q   <= (B == '0);
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        hi     <= '0;
                        lo     <= ALUcontrol_In[2] ? a_mag : b_mag;
                        opnd   <= ALUcontrol_In[2] ? b_mag : a_mag;
                    end
                end
                S_MUL: begin
                    if (cnt == LAST) begin
                        state <= S_IDLE;
                    end else begin
                        hi  <= mul_sum[XLEN:1];
                        lo  <= {mul_sum[0], lo[XLEN-1:1]};
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (cnt == LAST) begin
                        state <= S_IDLE;
                    end else begin
                        if (!div_diff[XLEN]) begin
                            hi <= div_diff[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= div_sh[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_alu_md_iter.sv
// tb_alu_md_iter: directed self-checking bench for alu_md_iter (XLEN=32, TAG_W=5).
// Checks the configured build: mul/div behaviour when ALU_MULDIV_EN is defined,
// illegal-op behaviour otherwise.
module tb_alu_md_iter;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic [31:0] a, b, result;
    logic [4:0]  tag, out_tag;
    logic        zero, illegal;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    int          lat, irl;

    alu_md_iter #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALUcontrol_In(op), .A(a), .B(b), .in_tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .Result(result),
        .Zero(zero), .Illegal(illegal), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for in_ready, then take the accepting edge.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t);
        int n;
        op = o; a = x; b = y; tag = t; in_valid = 1'b1;
        #0;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n == 100) check("accept_timeout", {63'b0, in_ready}, 64'd1);
        step();
    endtask

    task automatic expect_res(input string name, input logic [31:0] r, input logic [4:0] t,
                              input logic ill);
        check({name, "_valid"}, {63'b0, out_valid}, 64'd1);
        check({name, "_result"}, {32'b0, result}, {32'b0, r});
        check({name, "_zero"}, {63'b0, zero}, {63'b0, (r == 32'd0)});
        check({name, "_illegal"}, {63'b0, illegal}, {63'b0, ill});
        check({name, "_tag"}, {59'b0, out_tag}, {59'b0, t});
    endtask

    // Count cycles until out_valid (bounded) and how many of them had in_ready low.
    task automatic wait_res(input int budget, output int l, output int ir);
        l = 0;
        ir = 0;
        while (!out_valid && l < budget) begin
            if (!in_ready) ir++;
            step();
            l++;
        end
    endtask

    task automatic long_op(input string name, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] t, input logic [31:0] r);
        int l, ir;
        do_op(o, x, y, t);
        in_valid = 1'b0;
        wait_res(40, l, ir);
        check({name, "_latency"}, 64'(l), 64'd33);
        expect_res(name, r, t, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; a = '0; b = '0; tag = '0;
        step();
        step();
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        check("rst_zero", {63'b0, zero}, 64'd0);
        check("rst_illegal", {63'b0, illegal}, 64'd0);
        check("rst_tag", {59'b0, out_tag}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Back-to-back ADD then SUB: one result per cycle, in_ready stays high.
        op = 4'b0000; a = 32'd10; b = 32'd5; tag = 5'd1; in_valid = 1'b1;
        step();
        expect_res("add", 32'd15, 5'd1, 1'b0);
        check("add_in_ready", {63'b0, in_ready}, 64'd1);
        op = 4'b0001; a = 32'd10; b = 32'd10; tag = 5'd2;
        step();
        expect_res("sub", 32'd0, 5'd2, 1'b0);
        check("sub_in_ready", {63'b0, in_ready}, 64'd1);

        do_op(4'b0111, 32'hFFFF_FFF0, 32'd2, 5'd3);
        expect_res("sra", 32'hFFFF_FFFC, 5'd3, 1'b0);
        do_op(4'b1000, 32'hFFFF_FFFB, 32'd3, 5'd4);
        expect_res("slt", 32'd1, 5'd4, 1'b0);
        do_op(4'b1001, 32'hFFFF_FFFB, 32'd3, 5'd5);
        expect_res("sltu", 32'd0, 5'd5, 1'b0);
        do_op(4'b0101, 32'd1, 32'd36, 5'd6);
        expect_res("sll", 32'h0000_0010, 5'd6, 1'b0);
        do_op(4'b0110, 32'h8000_0000, 32'd31, 5'd7);
        expect_res("srl", 32'd1, 5'd7, 1'b0);
        do_op(4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 5'd8);
        expect_res("xor", 32'h0000_0FF0, 5'd8, 1'b0);
        do_op(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 5'd9);
        expect_res("and", 32'h0000_F000, 5'd9, 1'b0);
        do_op(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 5'd10);
        expect_res("or", 32'h0000_FFF0, 5'd10, 1'b0);
        in_valid = 1'b0;
        step();
        check("idle_out_valid", {63'b0, out_valid}, 64'd0);

`ifdef ALU_MULDIV_EN
        do_op(4'b1011, 32'h8000_0000, 32'h8000_0000, 5'd11);
        in_valid = 1'b0;
        wait_res(40, lat, irl);
        check("mulh_latency", 64'(lat), 64'd33);
        check("mulh_in_ready_low", 64'(irl), 64'd33);
        expect_res("mulh", 32'h4000_0000, 5'd11, 1'b0);
        long_op("mul", 4'b1010, 32'd7, 32'hFFFF_FFFD, 5'd12, 32'hFFFF_FFEB);
        long_op("div", 4'b1100, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD);
        long_op("rem", 4'b1110, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF);
        long_op("divu_by0", 4'b1101, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF);
        long_op("rem_by0", 4'b1110, 32'd5, 32'd0, 5'd16, 32'd5);
        long_op("div_ovf", 4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
        long_op("rem_ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);
        long_op("divu", 4'b1101, 32'd100, 32'd7, 5'd19, 32'd14);
        long_op("remu", 4'b1111, 32'd100, 32'd7, 5'd20, 32'd2);
`else
        for (int i = 10; i < 16; i++) begin
            do_op(4'(i), 32'd123, 32'd45, 5'(i));
            expect_res($sformatf("illegal_op%0d", i), 32'd0, 5'(i), 1'b1);
        end
        do_op(4'b0000, 32'd20, 32'd22, 5'd21);
        expect_res("add_legal", 32'd42, 5'd21, 1'b0);
        in_valid = 1'b0;
        step();
`endif

        // Consumer stall: result and tag held, new op not accepted until released.
        out_ready = 1'b0;
        do_op(4'b0000, 32'd1, 32'd2, 5'd22);
        expect_res("stall_add", 32'd3, 5'd22, 1'b0);
        op = 4'b0001; a = 32'd9; b = 32'd4; tag = 5'd23;
        for (int i = 0; i < 5; i++) begin
            #0;
            check("stall_in_ready", {63'b0, in_ready}, 64'd0);
            step();
            check("stall_result", {32'b0, result}, 64'd3);
            check("stall_tag", {59'b0, out_tag}, 64'd22);
            check("stall_valid", {63'b0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        step();
        expect_res("after_stall", 32'd5, 5'd23, 1'b0);
        in_valid = 1'b0;
        step();
        check("after_stall_drain", {63'b0, out_valid}, 64'd0);

        // Flush together with in_valid: op must not be accepted.
        op = 4'b0000; a = 32'd3; b = 32'd3; tag = 5'd24; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_in_valid_out_valid", {63'b0, out_valid}, 64'd0);
        step();
        check("flush_in_valid_dropped", {63'b0, out_valid}, 64'd0);
        check("flush_result_kept", {32'b0, result}, 64'd5);

`ifdef ALU_MULDIV_EN
        // Flush ten cycles into a divide: no result ever appears.
        do_op(4'b1100, 32'd100, 32'd3, 5'd25);
        in_valid = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_div_in_ready", {63'b0, in_ready}, 64'd1);
        check("flush_div_out_valid", {63'b0, out_valid}, 64'd0);
        wait_res(40, lat, irl);
        check("flush_div_no_result", {63'b0, out_valid}, 64'd0);

        // Reset in the middle of a multiply.
        do_op(4'b1010, 32'd7, 32'd9, 5'd26);
        in_valid = 1'b0;
        repeat (5) step();
`endif
        rst = 1'b1;
        step();
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_result", {32'b0, result}, 64'd0);
        check("midrst_zero", {63'b0, zero}, 64'd0);
        check("midrst_illegal", {63'b0, illegal}, 64'd0);
        check("midrst_tag", {59'b0, out_tag}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_release_in_ready", {63'b0, in_ready}, 64'd1);
        wait_res(40, lat, irl);
        check("midrst_no_result", {63'b0, out_valid}, 64'd0);
        do_op(4'b0000, 32'd2, 32'd2, 5'd27);
        in_valid = 1'b0;
        expect_res("post_rst_add", 32'd4, 5'd27, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
